// File: rtl/rram_ctrl_pkg.sv
// Shared constants for the RRAM controller datapath blocks.
package rram_ctrl_pkg;

  localparam int RRAM_OF_DATA_WIDTH = 32;
  localparam int RRAM_OF_DEPTH      = 64;

endpackage

// File: rtl/rram_ofifo_ram.sv
// Simple dual-port RAM for the output FIFO: synchronous write, registered read.
module rram_ofifo_ram #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 64,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register holds its value between reads; only it is reset, not the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rram_output_fifo.sv
// Output buffer between the RRAM read path and the host read interface:
// circular FIFO with peek, flush, sticky error flags and registered read-valid.
module rram_output_fifo
  import rram_ctrl_pkg::*;
#(
  parameter int  DATA_WIDTH = RRAM_OF_DATA_WIDTH,
  parameter int  DEPTH      = RRAM_OF_DEPTH,
  parameter int  AF_LEVEL   = DEPTH - 4,
  parameter int  AE_LEVEL   = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  peek_en,
  input  logic [AW-1:0]         peek_off,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          push_ok;
  logic          pop_ok;
  logic          peek_ok;
  logic          ovf_set;
  logic          udf_set;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;

  assign count        = occ;
  assign full         = (occ == CW'(DEPTH));
  assign empty        = (occ == '0);
  assign almost_full  = (occ >= CW'(AF_LEVEL));
  assign almost_empty = (occ <= CW'(AE_LEVEL));

  // Flush swallows every request in its cycle, including the error side effects.
  assign push_ok = wr_en && !full && !flush;
  assign pop_ok  = rd_en && !empty && !flush;
  assign peek_ok = peek_en && !rd_en && ({1'b0, peek_off} < occ) && !flush;
  assign ovf_set = wr_en && full && !flush;
  assign udf_set = rd_en && empty && !flush;

  assign ram_re    = pop_ok || peek_ok;
  assign ram_raddr = pop_ok ? rd_ptr : AW'(rd_ptr + peek_off);

  rram_ofifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ram_re;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rram_output_fifo.sv
// Scoreboard bench for rram_output_fifo with DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_rram_output_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          peek_en;
  logic [AW-1:0] peek_off;
  logic          flush;
  logic          err_clr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb[$];
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_udf;
  logic [DW-1:0] exp_word;

  rram_output_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .peek_en      (peek_en),
    .peek_off     (peek_off),
    .flush        (flush),
    .err_clr      (err_clr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one cycle of requests, advancing the reference model and scoreboard.
  task automatic tick(input logic w, input logic [DW-1:0] wd, input logic r,
                      input logic pk, input logic [AW-1:0] po,
                      input logic fl, input logic ec);
    int   cnt;
    logic push_ok;
    logic pop_ok;
    logic peek_ok;
    cnt     = model_q.size();
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    peek_ok = 1'b0;
    if (!fl) begin
      push_ok = w && (cnt < DEPTH);
      pop_ok  = r && (cnt > 0);
      peek_ok = pk && !r && (int'(po) < cnt);
      if (w && !push_ok) exp_ovf = 1'b1;
      if (r && !pop_ok) exp_udf = 1'b1;
    end
    if (ec) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (pop_ok) sb.push_back(model_q[0]);
    if (peek_ok) sb.push_back(model_q[po]);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(wd);
    end
    exp_valid = pop_ok || peek_ok;
    wr_en    = w;
    wr_data  = wd;
    rd_en    = r;
    peek_en  = pk;
    peek_off = po;
    flush    = fl;
    err_clr  = ec;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    peek_en  = 1'b0;
    peek_off = '0;
    flush    = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_data, rd_valid, count} !== {32'h0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL reset_data: got data=%h valid=%b count=%0d want 0/0/0", rd_data, rd_valid, count);
    end
    total++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 101000",
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 32'h10 + DW'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({count, almost_full, full, almost_empty} !==
          {CW'(i + 1), (i + 1 >= AF), (i + 1 == DEPTH), (i + 1 <= AE)}) begin
        bad++;
        $display("FAIL fill_status[%0d]: got cnt=%0d af=%b f=%b ae=%b want cnt=%0d", i, count,
                 almost_full, full, almost_empty, i + 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if (rd_valid !== exp_valid) begin
        bad++;
        $display("FAIL drain_valid[%0d]: got %b want %b", i, rd_valid, exp_valid);
      end
      if (exp_valid) begin
        exp_word = sb.pop_front();
        total++;
        if (rd_data !== exp_word) begin
          bad++;
          $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, exp_word);
        end
      end
    end
    total++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      bad++;
      $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", empty, count);
    end
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h20 + DW'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 32'h99, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    exp_word = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
      bad++;
      $display("FAIL full_rw_pop: got valid=%b data=%h want 1/%h", rd_valid, rd_data, exp_word);
    end
    total++;
    if (count !== CW'(model_q.size()) || overflow !== exp_ovf) begin
      bad++;
      $display("FAIL full_rw_state: got cnt=%0d ovf=%b want %0d/%b", count, overflow,
               model_q.size(), exp_ovf);
    end
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    tick(1'b1, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 32'h66, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    total++;
    if (overflow !== exp_ovf || full !== 1'b1) begin
      bad++;
      $display("FAIL clr_priority: got ovf=%b full=%b want %b/1", overflow, full, exp_ovf);
    end
    while (model_q.size() > 0) begin
      tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      exp_word = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        bad++;
        $display("FAIL full_drain: got valid=%b data=%h want 1/%h", rd_valid, rd_data, exp_word);
      end
    end
  endtask

  task automatic test_empty_boundary();
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b0 || underflow !== 1'b1) begin
      bad++;
      $display("FAIL empty_pop: got valid=%b udf=%b want 0/1", rd_valid, underflow);
    end
    tick(1'b1, 32'hAA, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd1 || empty !== 1'b0) begin
      bad++;
      $display("FAIL empty_rw: got valid=%b cnt=%0d empty=%b want 0/1/0", rd_valid, count, empty);
    end
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    exp_word = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word || underflow !== 1'b0) begin
      bad++;
      $display("FAIL empty_followup: got valid=%b data=%h udf=%b want 1/%h/0", rd_valid, rd_data,
               underflow, exp_word);
    end
  endtask

  task automatic test_peek();
    for (int i = 1; i <= 5; i++) tick(1'b1, DW'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    exp_word = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word || count !== 4'd5) begin
      bad++;
      $display("FAIL peek_hit: got valid=%b data=%h cnt=%0d want 1/%h/5", rd_valid, rd_data, count,
               exp_word);
    end
    tick(1'b0, '0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    total++;
    if (rd_valid !== exp_valid || count !== 4'd5 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL peek_miss: got valid=%b cnt=%0d udf=%b want 0/5/0", rd_valid, count, underflow);
    end
    tick(1'b0, '0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    exp_word = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word || count !== 4'd4) begin
      bad++;
      $display("FAIL peek_vs_pop: got valid=%b data=%h cnt=%0d want 1/%h/4", rd_valid, rd_data,
               count, exp_word);
    end
    while (model_q.size() > 0) begin
      tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      exp_word = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        bad++;
        $display("FAIL peek_drain: got valid=%b data=%h want 1/%h", rd_valid, rd_data, exp_word);
      end
    end
  endtask

  task automatic test_wrap();
    int   pushed;
    logic r;
    pushed = 0;
    while (pushed < 20 || model_q.size() > 0) begin
      if (pushed < 20) begin
        if (model_q.size() >= 7) r = 1'b1;
        else if (model_q.size() <= 1) r = 1'b0;
        else r = 1'($urandom_range(0, 1));
        tick(1'b1, 32'hC000_0000 + DW'(pushed), r, 1'b0, '0, 1'b0, 1'b0);
        pushed++;
      end else begin
        tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      end
      total++;
      if (rd_valid !== exp_valid || count !== CW'(model_q.size())) begin
        bad++;
        $display("FAIL wrap_ctl: got valid=%b cnt=%0d want %b/%0d", rd_valid, count, exp_valid,
                 model_q.size());
      end
      if (exp_valid) begin
        exp_word = sb.pop_front();
        total++;
        if (rd_data !== exp_word) begin
          bad++;
          $display("FAIL wrap_data: got %h want %h", rd_data, exp_word);
        end
      end
    end
  endtask

  task automatic test_flush_and_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 32'h40 + DW'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: got cnt=%0d empty=%b valid=%b want 0/1/0", count, empty, rd_valid);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h50 + DW'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    exp_word = sb.pop_front();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
      bad++;
      $display("FAIL flush_refill: got valid=%b data=%h want 1/%h", rd_valid, rd_data, exp_word);
    end
    rd_en = 1'b1;
    rst   = 1'b1;
    #1;
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got valid=%b cnt=%0d empty=%b want 0/0/1", rd_valid, count, empty);
    end
    model_q.delete();
    sb.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    rd_en   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL post_reset: got valid=%b cnt=%0d want 0/0", rd_valid, count);
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_en     = 1'b0;
    peek_en   = 1'b0;
    peek_off  = '0;
    flush     = 1'b0;
    err_clr   = 1'b0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_boundary();
    test_empty_boundary();
    test_peek();
    test_wrap();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
